// File: rtl/wash_phase_timer.sv
// wash_phase_timer: countdown timer for one phase of the wash sequence.
// Latency: a start sampled at edge k shows D seconds after k; timer_done follows edge k + D*TICKS_PER_SEC (+ paused cycles).
// Flow control: pause freezes the countdown; dropping start aborts silently back to IDLE.
//
// Ports:
//   clk, rst           - clock (rising edge) and synchronous active-high reset
//   start              - sequencer level: timer requested for the current phase
//   phase              - 001 fill, 010 wash, 100 rinse, 011 dry, 110 drain (others invalid)
//   program_selection  - 00 quick, 01 normal, 10 heavy, 11 delicate
//   pause              - level, freezes an active countdown
//   timer_done         - one-cycle pulse when the countdown reaches 0
//   busy / paused      - state indicators (RUN or PAUSED / PAUSED only)
//   remaining_sec      - seconds left, binary
//   display            - two-digit BCD copy of remaining_sec
//   bad_phase          - one-cycle pulse per cycle that start is held with an invalid phase
module wash_phase_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRE_W         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] phase,
    input  logic [1:0] program_selection,
    input  logic       pause,
    output logic       timer_done,
    output logic       busy,
    output logic       paused,
    output logic [7:0] remaining_sec,
    output logic [7:0] display,
    output logic       bad_phase
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] PH_FILL  = 3'b001;
    localparam logic [2:0] PH_WASH  = 3'b010;
    localparam logic [2:0] PH_RINSE = 3'b100;
    localparam logic [2:0] PH_DRY   = 3'b011;
    localparam logic [2:0] PH_DRAIN = 3'b110;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    function automatic logic phase_valid(input logic [2:0] ph);
        logic v;
        case (ph)
            PH_FILL, PH_WASH, PH_RINSE, PH_DRY, PH_DRAIN: v = 1'b1;
            default:                                      v = 1'b0;
        endcase
        return v;
    endfunction

    // Duration table in seconds, columns quick/normal/heavy/delicate.
    function automatic logic [7:0] duration(input logic [1:0] prog, input logic [2:0] ph);
        logic [7:0] d;
        d = 8'd0;
        case (ph)
            PH_FILL:  d = 8'd10;
            PH_DRAIN: d = 8'd10;
            PH_WASH: begin
                case (prog)
                    2'b00:   d = 8'd30;
                    2'b01:   d = 8'd60;
                    2'b10:   d = 8'd90;
                    default: d = 8'd45;
                endcase
            end
            PH_RINSE: begin
                case (prog)
                    2'b00:   d = 8'd20;
                    2'b01:   d = 8'd30;
                    2'b10:   d = 8'd40;
                    default: d = 8'd30;
                endcase
            end
            PH_DRY: begin
                case (prog)
                    2'b00:   d = 8'd20;
                    2'b01:   d = 8'd40;
                    2'b10:   d = 8'd60;
                    default: d = 8'd0;   // delicate skips the dryer entirely
                endcase
            end
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    // Only applied to table values (<= 90), so two digits always suffice.
    function automatic logic [7:0] to_bcd(input logic [7:0] bin);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(bin / 8'd10);
        units = 4'(bin % 8'd10);
        return {tens, units};
    endfunction

    // BCD decrement; never called with 00 because expiry stops the count at 1 -> 0.
    function automatic logic [7:0] bcd_dec(input logic [7:0] b);
        logic [7:0] r;
        if (b[3:0] == 4'd0) begin
            r = {b[7:4] - 4'd1, 4'd9};
        end else begin
            r = {b[7:4], b[3:0] - 4'd1};
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       disp_q, disp_d;
    logic [2:0]       ph_q, ph_d;
    logic             done_q, done_d;
    logic             bad_q, bad_d;

    logic             do_load;
    logic             do_count;
    logic             do_clear;
    logic [7:0]       load_dur;
    logic             cur_valid;

    assign load_dur  = duration(program_selection, phase);
    assign cur_valid = phase_valid(phase);

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        rem_d    = rem_q;
        disp_d   = disp_q;
        ph_d     = ph_q;
        done_d   = 1'b0;
        bad_d    = 1'b0;
        do_load  = 1'b0;
        do_count = 1'b0;
        do_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cur_valid) begin
                        do_load = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!start) begin
                    do_clear = 1'b1;
                end else if (cur_valid && (phase != ph_q)) begin
                    do_load = 1'b1;
                end else if (pause) begin
                    // Entering pause consumes this edge: no count, so pause wins over a coincident expiry.
                    state_d = S_PAUSED;
                end else begin
                    do_count = 1'b1;
                end
            end
            S_PAUSED: begin
                if (!start) begin
                    do_clear = 1'b1;
                end else if (!pause) begin
                    // The resume edge counts, so each PAUSED cycle delays expiry by exactly one cycle.
                    do_count = 1'b1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (cur_valid && (phase != ph_q)) begin
                    // Sequencer moved to the next phase without dropping start.
                    do_load = 1'b1;
                end
            end
            default: begin
                do_clear = 1'b1;
            end
        endcase

        if (do_clear) begin
            state_d = S_IDLE;
            pre_d   = '0;
            rem_d   = 8'd0;
            disp_d  = 8'h00;
        end

        if (do_load) begin
            ph_d   = phase;
            rem_d  = load_dur;
            disp_d = to_bcd(load_dur);
            pre_d  = '0;
            if (load_dur == 8'd0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end

        if (do_count) begin
            state_d = S_RUN;
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                rem_d  = rem_q - 8'd1;
                disp_d = bcd_dec(disp_q);
                if (rem_q == 8'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            rem_q   <= 8'd0;
            disp_q  <= 8'h00;
            ph_q    <= 3'b000;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            disp_q  <= disp_d;
            ph_q    <= ph_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

    assign timer_done    = done_q;
    assign bad_phase     = bad_q;
    assign remaining_sec = rem_q;
    assign display       = disp_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign paused        = (state_q == S_PAUSED);

endmodule

// File: tb/tb_wash_phase_timer.sv
module tb_wash_phase_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] phase;
    logic [1:0] program_selection;
    logic       pause;
    logic       timer_done;
    logic       busy;
    logic       paused;
    logic [7:0] remaining_sec;
    logic [7:0] display;
    logic       bad_phase;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_done_q[$];

    wash_phase_timer #(
        .TICKS_PER_SEC(4),
        .PRE_W        (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .phase            (phase),
        .program_selection(program_selection),
        .pause            (pause),
        .timer_done       (timer_done),
        .busy             (busy),
        .paused           (paused),
        .remaining_sec    (remaining_sec),
        .display          (display),
        .bad_phase        (bad_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: sampled at a negedge, cyc equals the index of the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; phase = 3'b000; program_selection = 2'b00; pause = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (remaining_sec !== 8'd0 || display !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_value: remaining=%0d display=%h, required 0/00", remaining_sec, display);
        end
        vectors++;
        if (busy !== 1'b0 || paused !== 1'b0 || timer_done !== 1'b0 || bad_phase !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%b paused=%b done=%b bad=%b, required all 0",
                     busy, paused, timer_done, bad_phase);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_countdown();
        int k; int e; bit seen;
        program_selection = 2'b00; phase = 3'b001; start = 1'b1;
        k = cyc + 1;
        exp_done_q.push_back(k + 40);
        @(negedge clk);
        vectors++;
        if (display !== 8'h10 || remaining_sec !== 8'd10 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_load: remaining=%0d display=%h busy=%b, required 10/10/1", remaining_sec, display, busy);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (display !== 8'h10) begin
            miscompares++;
            $display("FAIL fill_hold3: display=%h, required 10", display);
        end
        @(negedge clk);
        vectors++;
        if (display !== 8'h09 || remaining_sec !== 8'd9) begin
            miscompares++;
            $display("FAIL fill_first_tick: remaining=%0d display=%h, required 9/09", remaining_sec, display);
        end
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (timer_done === 1'b1) begin
                seen = 1'b1;
                e = exp_done_q.pop_front();
                vectors++;
                if (cyc !== e) begin
                    miscompares++;
                    $display("FAIL fill_done_time: edge=%0d, required %0d", cyc, e);
                end
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fill_done_busy: busy=%b, required 0", busy);
                end
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            void'(exp_done_q.pop_front());
            $display("FAIL fill_done_timeout: no timer_done within budget, required at edge %0d", k + 40);
        end
        @(negedge clk);
        vectors++;
        if (timer_done !== 1'b0 || busy !== 1'b0 || remaining_sec !== 8'd0) begin
            miscompares++;
            $display("FAIL fill_done_hold: done=%b busy=%b remaining=%0d, required 0/0/0", timer_done, busy, remaining_sec);
        end
    endtask

    // Entered from DONE with start still high.
    task automatic test_back_to_back();
        int k; int e; bit seen;
        phase = 3'b010; program_selection = 2'b10;
        k = cyc + 1;
        exp_done_q.push_back(k + 360);
        @(negedge clk);
        vectors++;
        if (remaining_sec !== 8'd90 || display !== 8'h90 || busy !== 1'b1 || timer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reload: remaining=%0d display=%h busy=%b done=%b, required 90/90/1/0",
                     remaining_sec, display, busy, timer_done);
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (timer_done === 1'b1) begin
                seen = 1'b1;
                e = exp_done_q.pop_front();
                vectors++;
                if (cyc !== e) begin
                    miscompares++;
                    $display("FAIL b2b_done_time: edge=%0d, required %0d", cyc, e);
                end
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            void'(exp_done_q.pop_front());
            $display("FAIL b2b_done_timeout: no timer_done, required at edge %0d", k + 360);
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || remaining_sec !== 8'd0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy=%b remaining=%0d, required 0/0", busy, remaining_sec);
        end
    endtask

    task automatic test_pause();
        int k; int r; int e; bit seen;
        program_selection = 2'b01; phase = 3'b010; start = 1'b1;
        k = cyc + 1;
        exp_done_q.push_back(k + 240 + 7);
        seen = 1'b0;
        for (int i = 0; i < 320 && !seen; i++) begin
            @(negedge clk);
            r = cyc - k;
            if (r >= 10 && r <= 16) begin
                vectors++;
                if (paused !== 1'b1 || remaining_sec !== 8'd58 || display !== 8'h58) begin
                    miscompares++;
                    $display("FAIL pause_window r=%0d: paused=%b remaining=%0d display=%h, required 1/58/58",
                             r, paused, remaining_sec, display);
                end
            end else if (r == 9 || r == 17) begin
                vectors++;
                if (paused !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pause_edge r=%0d: paused=%b busy=%b, required 0/1", r, paused, busy);
                end
            end
            if (timer_done === 1'b1) begin
                seen = 1'b1;
                e = exp_done_q.pop_front();
                vectors++;
                if (cyc !== e) begin
                    miscompares++;
                    $display("FAIL pause_done_time: edge=%0d, required %0d", cyc, e);
                end
            end
            if (r == 9)  pause = 1'b1;
            if (r == 16) pause = 1'b0;
        end
        if (!seen) begin
            vectors++; miscompares++;
            void'(exp_done_q.pop_front());
            $display("FAIL pause_done_timeout: no timer_done, required at edge %0d", k + 247);
        end
        pause = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_duration();
        int k; int e;
        program_selection = 2'b11; phase = 3'b011; start = 1'b1;
        k = cyc + 1;
        exp_done_q.push_back(k);
        @(negedge clk);
        vectors++;
        if (timer_done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_done: timer_done=%b, required 1", timer_done);
        end else begin
            e = exp_done_q.pop_front();
            vectors++;
            if (cyc !== e) begin
                miscompares++;
                $display("FAIL zero_done_time: edge=%0d, required %0d", cyc, e);
            end
        end
        vectors++;
        if (busy !== 1'b0 || remaining_sec !== 8'd0) begin
            miscompares++;
            $display("FAIL zero_state: busy=%b remaining=%0d, required 0/0", busy, remaining_sec);
        end
        @(negedge clk);
        vectors++;
        if (timer_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after: done=%b busy=%b, required 0/0", timer_done, busy);
        end
        start = 1'b0;
        if (exp_done_q.size() != 0) void'(exp_done_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_abort(input bit use_rst);
        int k; int cnt;
        program_selection = 2'b00; phase = 3'b010; start = 1'b1;
        k = cyc + 1;
        while (cyc - k < 20 && cyc - k < 100) @(negedge clk);
        vectors++;
        if (remaining_sec !== 8'd25 || display !== 8'h25) begin
            miscompares++;
            $display("FAIL abort_pre rst=%0d: remaining=%0d display=%h, required 25/25", use_rst, remaining_sec, display);
        end
        if (use_rst) rst = 1'b1;
        else         start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || remaining_sec !== 8'd0 || display !== 8'h00 || timer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle rst=%0d: busy=%b remaining=%0d display=%h done=%b, required 0/0/00/0",
                     use_rst, busy, remaining_sec, display, timer_done);
        end
        rst = 1'b0; start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (timer_done === 1'b1) cnt++;
        end
        vectors++;
        if (cnt !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done rst=%0d: pulses=%0d, required 0", use_rst, cnt);
        end
    endtask

    task automatic test_bad_phase();
        int k; int e; bit seen;
        logic [2:0] bad_codes [2];
        bad_codes[0] = 3'b000; bad_codes[1] = 3'b101;
        program_selection = 2'b01; start = 1'b1;
        for (int c = 0; c < 2; c++) begin
            phase = bad_codes[c];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                vectors++;
                if (bad_phase !== 1'b1 || busy !== 1'b0 || remaining_sec !== 8'd0) begin
                    miscompares++;
                    $display("FAIL bad_phase code=%b cyc%0d: bad=%b busy=%b remaining=%0d, required 1/0/0",
                             bad_codes[c], i, bad_phase, busy, remaining_sec);
                end
            end
        end
        phase = 3'b110;
        k = cyc + 1;
        exp_done_q.push_back(k + 40);
        @(negedge clk);
        vectors++;
        if (bad_phase !== 1'b0 || remaining_sec !== 8'd10 || display !== 8'h10 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_load: bad=%b remaining=%0d display=%h busy=%b, required 0/10/10/1",
                     bad_phase, remaining_sec, display, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (timer_done === 1'b1) begin
                seen = 1'b1;
                e = exp_done_q.pop_front();
                vectors++;
                if (cyc !== e) begin
                    miscompares++;
                    $display("FAIL drain_done_time: edge=%0d, required %0d", cyc, e);
                end
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            void'(exp_done_q.pop_front());
            $display("FAIL drain_done_timeout: no timer_done, required at edge %0d", k + 40);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill_countdown();
        test_back_to_back();
        test_pause();
        test_zero_duration();
        test_abort(1'b0);
        test_abort(1'b1);
        test_bad_phase();
        vectors++;
        if (exp_done_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected pulses outstanding, required 0", exp_done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
